adder_settle_sequencer: RTL

Clocked front-end/back-end stage wrapped around the `fourbit_with_delay` ripple adder. It accepts operand triples over a valid/ready handshake and drives them onto the adder's A/B/Cin. It then waits a fixed number of settle cycles to cover the adder's gate delays, and captures Sum/Cout. The captured result goes out on a valid/ready handshake, together with a mismatch flag against an internal behavioural reference sum and a saturating error counter.

---
 rtl/adder_settle_sequencer.sv | 121 ++++++++++++
 1 files changed

// File: rtl/adder_settle_sequencer.sv
// Valid/ready wrapper around a slow ripple adder. It drives the operands, waits a
// fixed number of settle cycles, then captures Sum/Cout and checks them against a reference sum.
module adder_settle_sequencer #(
  parameter int WIDTH         = 4,
  parameter int SETTLE_CYCLES = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_cin,
  input  logic [WIDTH-1:0] add_sum,
  input  logic             add_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_err,
  output logic [7:0]       err_count
);

  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

  localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] add_a_q, add_a_d, add_b_q, add_b_d;
  logic             add_cin_q, add_cin_d;
  logic [WIDTH:0]   ref_q, ref_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             err_q, err_d;
  logic [7:0]       ecnt_q, ecnt_d;
  logic             mism;

  assign mism = ({add_cout, add_sum} != ref_q);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    add_a_d   = add_a_q;
    add_b_d   = add_b_q;
    add_cin_d = add_cin_q;
    ref_d     = ref_q;
    sum_d     = sum_q;
    cout_d    = cout_q;
    err_d     = err_q;
    ecnt_d    = ecnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          add_a_d   = in_a;
          add_b_d   = in_b;
          add_cin_d = in_cin;
          // Zero-extended to WIDTH+1 so the carry-out can never wrap.
          ref_d     = {1'b0, in_a} + {1'b0, in_b} + {{WIDTH{1'b0}}, in_cin};
          cnt_d     = CNT_INIT;
          state_d   = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q == 4'd0) begin
          sum_d   = add_sum;
          cout_d  = add_cout;
          err_d   = mism;
          if (mism && ecnt_q != 8'hFF) ecnt_d = ecnt_q + 8'd1;
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      HOLD: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      add_a_q   <= '0;
      add_b_q   <= '0;
      add_cin_q <= 1'b0;
      ref_q     <= '0;
      sum_q     <= '0;
      cout_q    <= 1'b0;
      err_q     <= 1'b0;
      ecnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      add_a_q   <= add_a_d;
      add_b_q   <= add_b_d;
      add_cin_q <= add_cin_d;
      ref_q     <= ref_d;
      sum_q     <= sum_d;
      cout_q    <= cout_d;
      err_q     <= err_d;
      ecnt_q    <= ecnt_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == HOLD);
  assign add_a     = add_a_q;
  assign add_b     = add_b_q;
  assign add_cin   = add_cin_q;
  assign out_sum   = sum_q;
  assign out_cout  = cout_q;
  assign out_err   = err_q;
  assign err_count = ecnt_q;

endmodule
